fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_ctrl.sv | 81 ++++++++
 tb/tb_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller and its buffer.
package fetch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer: one enqueue and one dequeue per cycle, with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq,
  input  fetch_entry_t             enq_entry,
  input  logic                     deq,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= enq_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation into a small buffer,
// redirect flush, and a ready/valid handoff to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        busy,
  output logic [31:0] instr_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  enq_entry;
  logic          enq;
  logic          deq;
  logic          room;
  logic          unused_ok;

  // Redirect wins over both ends of the buffer; a full buffer still accepts
  // when the head leaves in the same cycle.
  assign deq       = (count != '0) && if_ready && !redirect_valid;
  assign room      = (count < CW'(FIFO_DEPTH)) || deq;
  assign enq       = (state == FETCH) && run && !redirect_valid && room;
  assign enq_entry = '{pc: fetch_pc, instr: imem_rd};
  assign unused_ok = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      instr_count <= '0;
    end else begin
      state <= run ? FETCH : IDLE;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (enq)
        fetch_pc <= fetch_pc + 32'd4;
      if (deq)
        instr_count <= instr_count + 32'd1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq),
    .enq_entry (enq_entry),
    .deq       (deq),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign imem_addr   = fetch_pc;
  assign if_valid    = (count != '0);
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = head.pc + 32'd4;
  assign busy        = (state == FETCH) || (count != '0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected instruction stream queued by stimulus,
// popped and compared by a monitor on every decode handshake.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        busy;
  logic [31:0] instr_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] tail_pc;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .busy           (busy),
    .instr_count    (instr_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h8C01_0007;
      32'h0000_0004: return 32'h2021_0001;
      32'h0000_0008: return 32'hAC01_0002;
      default:       return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_rd = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: tail_pc, instr: mem_word(tail_pc)});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] target);
    exp_q.delete();
    tail_pc = {target[31:2], 2'b00};
    top_up();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    restart_stream(target);
  endtask

  // Monitor: pops one expected entry per handshake and tracks the handshake count.
  int unsigned model_cnt;
  logic        prev_redir;
  logic        prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_cnt  = 0;
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      chk("instr_count", instr_count, model_cnt);
      if (prev_redir) chk("valid_after_redirect", {31'd0, if_valid}, 32'd0);
      if (prev_hold) begin
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_instr", if_instr, prev_instr);
      end
      if (if_valid) chk("pc_plus4", if_pc_plus4, if_pc + 32'd4);
      if (if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_underrun actual=pc %h expected=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", if_pc, e.pc);
          chk("stream_instr", if_instr, e.instr);
        end
        model_cnt++;
      end
      prev_redir = redirect_valid;
      prev_hold  = if_valid && !if_ready && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] c0;
    rst_n = 1'b0; run = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tail_pc = '0;
    #2;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    #10;

    // Start-up latency and first three instructions.
    rst_n = 1'b1;
    restart_stream(32'h0);
    run = 1'b1; if_ready = 1'b1;
    step();
    chk("edge1_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("edge2_valid", {31'd0, if_valid}, 32'd1);
    chk("edge2_pc", if_pc, 32'h0);
    chk("edge2_instr", if_instr, 32'h8C01_0007);
    step();
    chk("edge3_pc", if_pc, 32'h4);
    chk("edge3_instr", if_instr, 32'h2021_0001);
    step();
    chk("edge4_pc", if_pc, 32'h8);
    chk("edge4_instr", if_instr, 32'hAC01_0002);

    // Back-pressure: buffer fills, fetch address stalls.
    if_ready = 1'b0;
    do_redirect(32'h0);
    step();
    redirect_valid = 1'b0;
    repeat (5) step();
    chk("stall_valid", {31'd0, if_valid}, 32'd1);
    chk("stall_pc", if_pc, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    if_ready = 1'b1;
    step();
    chk("release_pc1", if_pc, 32'h4);
    step();
    chk("release_pc2", if_pc, 32'h8);
    step();

    // Redirect colliding with a dequeue.
    c0 = instr_count;
    do_redirect(32'h0000_0006);
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_count", instr_count, c0);
    step();
    chk("redir_tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_tgt_pc", if_pc, 32'h4);
    chk("redir_tgt_instr", if_instr, 32'h2021_0001);

    // Address wrap at the top of memory.
    if_ready = 1'b0;
    do_redirect(32'hFFFF_FFFD);
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", if_pc_plus4, 32'h0);
    step();

    // Stop with two entries buffered: drain, then go idle.
    chk("drain_busy0", {31'd0, busy}, 32'd1);
    run = 1'b0; if_ready = 1'b1;
    chk("drain_addr0", imem_addr, 32'h4);
    step();
    chk("drain_busy1", {31'd0, busy}, 32'd1);
    chk("drain_valid1", {31'd0, if_valid}, 32'd1);
    chk("drain_pc1", if_pc, 32'h0);
    step();
    chk("drain_busy2", {31'd0, busy}, 32'd0);
    chk("drain_valid2", {31'd0, if_valid}, 32'd0);
    chk("drain_addr2", imem_addr, 32'h4);
    step();
    chk("drain_addr3", imem_addr, 32'h4);

    // Randomised traffic against the queued stream.
    run = 1'b1;
    repeat (400) begin
      if_ready = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) run = ~run;
      if ($urandom_range(19) == 0) do_redirect($urandom);
      else redirect_valid = 1'b0;
      top_up();
      step();
    end
    redirect_valid = 1'b0;
    top_up();
    step();

    // Asynchronous reset in the middle of a stall.
    run = 1'b1; if_ready = 1'b0;
    do_redirect(32'h0000_0100);
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_count", instr_count, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_pc", if_pc, 32'h0);
    step();
    step();
    run = 1'b0;
    rst_n = 1'b1;
    restart_stream(32'h0);
    step();
    chk("post_rst_valid", {31'd0, if_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
